vx_csa_accum: RTL and testbench

Streaming carry-save accumulator with a handshake interface. It sits at the consumer end of the carry-save reduction datapath. Each accepted beat of N operands is folded into a running sum that is kept in redundant (sum, carry) form, so no carry propagates on the per-beat path. When a frame ends, the redundant pair is resolved into binary by a multi-cycle segmented carry-propagate adder, and the result is presented on an output handshake. Dot-product and reduction units use it when operand counts exceed what one combinational tree handles per cycle.

---
 rtl/vx_csa_accum.sv | 140 ++++++++++++++
 tb/tb_vx_csa_accum.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_csa_accum.sv
// rtl/vx_csa_accum.sv - streaming carry-save accumulator with segmented resolve
// Beats fold into a redundant (sum, carry) pair; frame end resolves it SEG bits per cycle.

module vx_csa_accum #(
   parameter int N      = 4,
   parameter int W      = 8,
   parameter int ACC_W  = 32,
   parameter int SEG    = 8,
   parameter int CNT_W  = 16,
   parameter int SIGNED = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*W-1:0]     in_operands,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic [CNT_W-1:0]   out_beats
);

   localparam int NSEG   = (ACC_W + SEG - 1) / SEG;
   localparam int PAD_W  = NSEG * SEG;
   localparam int SIDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ACC_W-1:0]    acc_s;
   logic [ACC_W-1:0]    acc_c;
   logic [CNT_W-1:0]    count;
   logic [SIDX_W-1:0]   seg_idx;
   logic                carry;
   logic [PAD_W-1:0]    result;

   logic [ACC_W-1:0]    csa_s;
   logic [ACC_W-1:0]    csa_c;
   logic [ACC_W-1:0]    ext;
   logic [ACC_W-1:0]    maj;
   logic [PAD_W-1:0]    s_pad;
   logic [PAD_W-1:0]    c_pad;
   logic [SEG:0]        seg_sum;

   // Chain of 3:2 compressors: each operand is absorbed without any carry ripple.
   always_comb begin
      csa_s = acc_s;
      csa_c = acc_c;
      ext   = '0;
      maj   = '0;
      for (int i = 0; i < N; i++) begin
         ext = '0;
         for (int b = 0; b < W; b++) begin
            ext[b] = in_operands[i*W + b];
         end
         for (int b = W; b < ACC_W; b++) begin
            ext[b] = (SIGNED != 0) && in_operands[i*W + W - 1];
         end
         maj   = (csa_s & csa_c) | (csa_s & ext) | (csa_c & ext);
         csa_s = csa_s ^ csa_c ^ ext;
         csa_c = maj << 1;
      end
   end

   always_comb begin
      s_pad   = PAD_W'(acc_s);
      c_pad   = PAD_W'(acc_c);
      seg_sum = {1'b0, s_pad[seg_idx*SEG +: SEG]} + {1'b0, c_pad[seg_idx*SEG +: SEG]}
              + {{SEG{1'b0}}, carry};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM:   if (in_valid && in_last) state_d = ST_RESOLVE;
         ST_RESOLVE: if (seg_idx == SIDX_W'(NSEG - 1)) state_d = ST_OUTPUT;
         ST_OUTPUT:  if (out_ready) state_d = ST_ACCUM;
         default:    state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_s   <= '0;
         acc_c   <= '0;
         count   <= '0;
         seg_idx <= '0;
         carry   <= 1'b0;
         result  <= '0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (in_valid) begin
                  acc_s <= csa_s;
                  acc_c <= csa_c;
                  if (count != '1) count <= count + 1'b1;
                  if (in_last) begin
                     seg_idx <= '0;
                     carry   <= 1'b0;
                  end
               end
            end
            ST_RESOLVE: begin
               // Bits above ACC_W in the top segment are padding and never reach out_sum.
               result[seg_idx*SEG +: SEG] <= seg_sum[SEG-1:0];
               carry                      <= seg_sum[SEG];
               seg_idx                    <= seg_idx + 1'b1;
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  acc_s <= '0;
                  acc_c <= '0;
                  count <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_OUTPUT);
   assign out_sum   = result[ACC_W-1:0];
   assign out_beats = count;

endmodule

// File: tb/tb_vx_csa_accum.sv
// tb/tb_vx_csa_accum.sv - self-checking bench for vx_csa_accum
// Three instances (unsigned, signed, 10-bit wrap) share the input stream.

module tb_vx_csa_accum;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] in_operands;
   logic        in_last;
   logic        out_ready;

   logic        rdy_d, vld_d, rdy_s, vld_s, rdy_w, vld_w;
   logic [31:0] sum_d, sum_s;
   logic [9:0]  sum_w;
   logic [15:0] beats_d, beats_s, beats_w;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int accept_cyc;
   int first_d, first_s, first_w;

   longint mu;
   longint ms;
   int     nb;

   vx_csa_accum u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_d),
      .in_operands(in_operands), .in_last(in_last), .out_valid(vld_d),
      .out_ready(out_ready), .out_sum(sum_d), .out_beats(beats_d)
   );

   vx_csa_accum #(.SIGNED(1)) u_sgn (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_s),
      .in_operands(in_operands), .in_last(in_last), .out_valid(vld_s),
      .out_ready(out_ready), .out_sum(sum_s), .out_beats(beats_s)
   );

   vx_csa_accum #(.ACC_W(10), .SEG(8)) u_wrap (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_w),
      .in_operands(in_operands), .in_last(in_last), .out_valid(vld_w),
      .out_ready(out_ready), .out_sum(sum_w), .out_beats(beats_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      mu = 0;
      ms = 0;
      nb = 0;
   endtask

   task automatic send_beat(input logic [31:0] ops, input logic last);
      logic [7:0] b;
      chk("in_ready_before_beat", {61'd0, rdy_d, rdy_s, rdy_w}, 64'd7);
      in_valid    = 1'b1;
      in_operands = ops;
      in_last     = last;
      @(posedge clk);
      #1;
      accept_cyc  = cyc;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      in_operands = $urandom;
      for (int i = 0; i < 4; i++) begin
         b  = ops[i*8 +: 8];
         mu = mu + longint'(b);
         ms = ms + longint'($signed(b));
      end
      nb++;
   endtask

   // A sample #1 after edge e lies in cycle e+1; first valid must appear NSEG edges after acceptance.
   task automatic collect(input logic check_lat);
      int budget;
      first_d = -1; first_s = -1; first_w = -1;
      budget  = 0;
      chk("valid_low_at_accept", {61'd0, vld_d, vld_s, vld_w}, 64'd0);
      while (!(vld_d && vld_s && vld_w) && budget < 40) begin
         @(posedge clk);
         #1;
         budget++;
         if (vld_d && first_d < 0) first_d = cyc;
         if (vld_s && first_s < 0) first_s = cyc;
         if (vld_w && first_w < 0) first_w = cyc;
         if (vld_d || vld_s || vld_w)
            chk("ready_low_when_valid", {61'd0, rdy_d & vld_d, rdy_s & vld_s, rdy_w & vld_w}, 64'd0);
      end
      chk("valid_timeout", {63'd0, vld_d && vld_s && vld_w}, 64'd1);
      if (check_lat) begin
         chk("latency_nseg4", 64'(first_d - accept_cyc), 64'd4);
         chk("latency_nseg2", 64'(first_w - accept_cyc), 64'd2);
      end
   endtask

   task automatic check_result(input string nm, input logic [31:0] ed, input logic [31:0] es,
                               input logic [9:0] ew, input int eb);
      chk({nm, "_sum_u"}, 64'(sum_d), 64'(ed));
      chk({nm, "_sum_s"}, 64'(sum_s), 64'(es));
      chk({nm, "_sum_w"}, 64'(sum_w), 64'(ew));
      chk({nm, "_beats"}, 64'(beats_d), 64'(eb));
      chk({nm, "_beats_w"}, 64'(beats_w), 64'(eb));
   endtask

   task automatic check_model(input string nm);
      check_result(nm, mu[31:0], ms[31:0], mu[9:0], nb);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("ready_after_handshake", {61'd0, rdy_d, rdy_s, rdy_w}, 64'd7);
      chk("valid_after_handshake", {61'd0, vld_d, vld_s, vld_w}, 64'd0);
      model_clear();
   endtask

   typedef struct {
      logic [31:0] ops;
      logic [31:0] exp_u;
      logic [31:0] exp_s;
      logic [9:0]  exp_w;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{32'h04030201, 32'd10,  32'd10,        10'd10};
      vecs[1] = '{32'h8001FFFF, 32'd639, 32'hFFFFFF7F,  10'd639};
      vecs[2] = '{32'h00000000, 32'd0,   32'd0,         10'd0};
      vecs[3] = '{32'h00000005, 32'd5,   32'd5,         10'd5};

      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_operands = '0;
      in_last     = 1'b0;
      out_ready   = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", {61'd0, rdy_d, rdy_s, rdy_w}, 64'd7);
      chk("reset_out_valid", {61'd0, vld_d, vld_s, vld_w}, 64'd0);
      chk("reset_out_sum", 64'(sum_d), 64'd0);
      chk("reset_out_beats", 64'(beats_d), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[k]) begin
         send_beat(vecs[k].ops, 1'b1);
         collect(1'b1);
         check_result($sformatf("vec%0d", k), vecs[k].exp_u, vecs[k].exp_s, vecs[k].exp_w, 1);
         handshake();
      end

      for (int k = 0; k < 3; k++) send_beat(32'hFFFFFFFF, k == 2);
      collect(1'b1);
      check_result("three_ff", 32'd3060, 32'hFFFFFFF4, 10'd1012, 3);
      handshake();

      for (int k = 0; k < 2; k++) send_beat(32'hFFFFFFFF, k == 1);
      collect(1'b1);
      check_result("wrap_two_ff", 32'd2040, 32'hFFFFFFF8, 10'd1016, 2);
      handshake();

      send_beat(32'h0A141E28, 1'b1);
      collect(1'b0);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {63'd0, vld_d}, 64'd1);
         chk("bp_sum", 64'(sum_d), 64'd100);
         chk("bp_beats", 64'(beats_d), 64'd1);
         chk("bp_ready", {63'd0, rdy_d}, 64'd0);
         @(posedge clk);
         #1;
      end
      handshake();
      send_beat(32'h01010101, 1'b1);
      collect(1'b1);
      check_result("after_bp", 32'd4, 32'd4, 10'd4, 1);
      handshake();

      send_beat(32'h07070707, 1'b0);
      send_beat(32'h07070707, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_valid", {61'd0, vld_d, vld_s, vld_w}, 64'd0);
      chk("rst_mid_sum", 64'(sum_d), 64'd0);
      chk("rst_mid_sum_w", 64'(sum_w), 64'd0);
      chk("rst_mid_ready", {61'd0, rdy_d, rdy_s, rdy_w}, 64'd7);
      @(posedge clk);
      #1;
      chk("rst_held_valid", {63'd0, vld_d}, 64'd0);
      reset_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      send_beat(32'h00000005, 1'b1);
      collect(1'b1);
      check_result("after_reset", 32'd5, 32'd5, 10'd5, 1);
      handshake();

      for (int f = 0; f < 20; f++) begin
         int len;
         len = $urandom_range(1, 5);
         for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send_beat($urandom, k == len - 1);
         end
         collect(1'b1);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         check_model($sformatf("rand%0d", f));
         handshake();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
